// File: rtl/ppm_mod_if.sv
// ppm_mod_if: payload byte stream handshake between a byte source and the PPM modulator
interface ppm_mod_if;
    logic [7:0] byte_in;
    logic       byte_valid;
    logic       byte_last;
    logic       byte_ready;
    modport master (output byte_in, byte_valid, byte_last, input byte_ready);
    modport slave  (input byte_in, byte_valid, byte_last, output byte_ready);
endinterface

// File: rtl/ppm_mod.sv
// ppm_mod: 4-PPM line modulator with one-entry byte hold register and illegal-code end marker
module ppm_mod #(
    parameter int SLOT_CYC = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    ppm_mod_if.slave   bus,
    output logic       ppm_out,
    output logic       busy,
    output logic       frame_done,
    output logic       underrun
);
    typedef enum logic [1:0] {IDLE, PRELOAD, SEND, EOF} state_t;
    localparam logic [7:0] CNT_MAX = 8'(SLOT_CYC - 1);
    state_t     state, n_state;
    logic [7:0] slot_cnt, n_cnt, hold, n_hold, sh, n_sh;
    logic [1:0] slot_idx, n_slot, sym_idx, n_sym, n_sym_val;
    logic       hold_last, n_hold_last, hold_full, n_hold_full, last_seen, n_last_seen;
    logic       sh_last, n_sh_last, n_done, n_under, n_ppm, load, accept, run;
    logic       cnt_wrap, slot_wrap, byte_wrap;
    assign bus.byte_ready = (state == PRELOAD || state == SEND) && !hold_full && !last_seen;
    assign accept    = bus.byte_valid && bus.byte_ready;
    assign run       = state == SEND || state == EOF;
    assign cnt_wrap  = slot_cnt == CNT_MAX;
    assign slot_wrap = cnt_wrap && slot_idx == 2'd3;
    assign byte_wrap = slot_wrap && sym_idx == 2'd3;
    always_comb begin
        n_state     = state;
        n_hold      = hold;
        n_hold_last = hold_last;
        n_hold_full = hold_full;
        n_last_seen = last_seen;
        n_sh        = sh;
        n_sh_last   = sh_last;
        n_done      = 1'b0;
        n_under     = 1'b0;
        load        = 1'b0;
        case (state)
            IDLE:    n_state = start ? PRELOAD : IDLE;
            PRELOAD: begin
                load    = hold_full;
                n_state = hold_full ? SEND : PRELOAD;
            end
            SEND: if (byte_wrap) begin
                load    = !sh_last && hold_full;
                n_under = !sh_last && !hold_full;
                n_state = load ? SEND : EOF;
            end
            default: if (slot_wrap) begin
                n_state = IDLE;
                n_done  = 1'b1;
            end
        endcase
        if (load) begin
            n_sh        = hold;
            n_sh_last   = hold_last;
            n_hold_full = 1'b0;
        end
        if (accept) begin
            n_hold      = bus.byte_in;
            n_hold_last = bus.byte_last;
            n_hold_full = 1'b1;
            n_last_seen = last_seen || bus.byte_last;
        end
        if (n_done) begin
            n_hold_full = 1'b0;
            n_last_seen = 1'b0;
        end
        n_cnt     = (run && !cnt_wrap) ? slot_cnt + 8'd1 : 8'd0;
        n_slot    = run ? slot_idx + 2'(cnt_wrap) : 2'd0;
        n_sym     = run ? sym_idx + 2'(slot_wrap) : 2'd0;
        n_sym_val = n_sh[{~n_sym, 1'b1} -: 2];
        // output is registered from the next-cycle counters so the line changes on the slot edge itself
        n_ppm = (n_state == SEND) ? (n_slot != n_sym_val) :
                (n_state == EOF)  ? n_slot[0] : 1'b1;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            slot_cnt   <= 8'd0;
            slot_idx   <= 2'd0;
            sym_idx    <= 2'd0;
            hold       <= 8'd0;
            hold_last  <= 1'b0;
            hold_full  <= 1'b0;
            last_seen  <= 1'b0;
            sh         <= 8'd0;
            sh_last    <= 1'b0;
            ppm_out    <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            state      <= n_state;
            slot_cnt   <= n_cnt;
            slot_idx   <= n_slot;
            sym_idx    <= n_sym;
            hold       <= n_hold;
            hold_last  <= n_hold_last;
            hold_full  <= n_hold_full;
            last_seen  <= n_last_seen;
            sh         <= n_sh;
            sh_last    <= n_sh_last;
            ppm_out    <= n_ppm;
            busy       <= n_state != IDLE;
            frame_done <= n_done;
            underrun   <= n_under;
        end
    end
endmodule

// File: tb/tb_ppm_mod.sv
// tb_ppm_mod: directed checks of ppm_mod timing against hand-computed cycle numbers
module tb_ppm_mod;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic [7:0] byte_in = 8'd0;
    logic byte_valid = 1'b0;
    logic byte_last = 1'b0;
    logic sel = 1'b0;
    logic ppm_a, busy_a, done_a, und_a, ppm_b, busy_b, done_b, und_b;
    logic ppm, busy, done, und, rdy;
    int errors = 0;
    int checks = 0;
    int acc0;
    logic [7:0] qb [4];
    logic ql [4];
    logic lo [0:700];
    logic dn [0:700];
    logic un [0:700];
    logic rd [0:700];
    logic bz [0:700];
    int ivs [$];
    int ive [$];

    ppm_mod_if ifa ();
    ppm_mod_if ifb ();
    assign ifa.byte_in = byte_in;
    assign ifa.byte_valid = byte_valid;
    assign ifa.byte_last = byte_last;
    assign ifb.byte_in = byte_in;
    assign ifb.byte_valid = byte_valid;
    assign ifb.byte_last = byte_last;

    ppm_mod #(.SLOT_CYC(16)) dut_a (.clk(clk), .rst_n(rst_n), .start(start), .bus(ifa.slave),
        .ppm_out(ppm_a), .busy(busy_a), .frame_done(done_a), .underrun(und_a));
    ppm_mod #(.SLOT_CYC(2)) dut_b (.clk(clk), .rst_n(rst_n), .start(start), .bus(ifb.slave),
        .ppm_out(ppm_b), .busy(busy_b), .frame_done(done_b), .underrun(und_b));

    assign ppm  = sel ? ppm_b : ppm_a;
    assign busy = sel ? busy_b : busy_a;
    assign done = sel ? done_b : done_a;
    assign und  = sel ? und_b : und_a;
    assign rdy  = sel ? ifb.byte_ready : ifa.byte_ready;

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // runs one frame: start pulse, optional PRELOAD wait, then n cycles feeding qb/ql when ready
    task automatic frame(input int pre, input int nb, input int n, input int start_at);
        int bi = 0;
        logic fire;
        acc0 = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < pre; i++) begin
            chk("preload_ppm", ppm, 1);
            chk("preload_busy", busy, 1);
            chk("preload_ready", rdy, 1);
            step();
        end
        for (int s = 1; s <= n; s++) begin
            byte_valid = bi < nb;
            byte_in = qb[bi < nb ? bi : 0];
            byte_last = ql[bi < nb ? bi : 0];
            start = acc0 != 0 && s - acc0 == start_at;
            fire = byte_valid && rdy;
            step();
            if (fire) begin
                if (acc0 == 0) acc0 = s;
                bi++;
            end
            lo[s] = ppm; dn[s] = done; un[s] = und; rd[s] = rdy; bz[s] = busy;
        end
        byte_valid = 1'b0;
        start = 1'b0;
        chk("accepted", acc0 != 0, 1);
        if (acc0 == 0) acc0 = 1;
    endtask

    task automatic chk_ppm(input int endc);
        logic e;
        for (int c = 0; c <= endc; c++) begin
            e = 1'b1;
            foreach (ivs[i]) if (c >= ivs[i] && c <= ive[i]) e = 1'b0;
            chk($sformatf("ppm_c%0d", c), lo[acc0 + c], e);
        end
    endtask

    task automatic chk_tail(input int done_c, input int und_c, input int endc);
        int nd = 0, fd = -1, nu = 0, fu = -1;
        for (int c = 0; c <= endc; c++) begin
            if (dn[acc0 + c]) begin nd++; if (fd < 0) fd = c; end
            if (un[acc0 + c]) begin nu++; if (fu < 0) fu = c; end
        end
        chk("done_cycle", fd, done_c);
        chk("done_count", nd, 1);
        chk("underrun_cycle", fu, und_c);
        chk("underrun_count", nu, und_c >= 0 ? 1 : 0);
        chk("busy_before_done", bz[acc0 + done_c - 1], 1);
        chk("busy_after_done", bz[acc0 + done_c], 0);
    endtask

    task automatic chk_quiet(input int from, input int endc);
        int nr = 0;
        for (int c = from; c <= endc; c++) if (rd[acc0 + c]) nr++;
        chk("ready_quiet", nr, 0);
    endtask

    initial begin
        step(); step(); step();
        chk("rst_ppm", ppm, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_underrun", und, 0);
        chk("rst_ready", rdy, 0);
        rst_n = 1'b1;
        step();
        byte_valid = 1'b1;
        byte_in = 8'h55;
        for (int i = 0; i < 5; i++) begin
            chk("idle_ready", rdy, 0);
            chk("idle_busy", busy, 0);
            step();
        end
        byte_valid = 1'b0;

        // single byte 0x1B with last, stray start mid-frame
        qb[0] = 8'h1B; ql[0] = 1'b1;
        frame(4, 1, 331, 100);
        ivs = '{1, 81, 161, 241, 257, 289};
        ive = '{16, 96, 176, 256, 272, 304};
        chk_ppm(330);
        chk_tail(321, -1, 330);
        chk_quiet(1, 330);

        // 0x00 then 0xFF back to back
        qb[0] = 8'h00; ql[0] = 1'b0; qb[1] = 8'hFF; ql[1] = 1'b1;
        frame(0, 2, 591, -1);
        ivs = '{1, 65, 129, 193, 305, 369, 433, 497, 513, 545};
        ive = '{16, 80, 144, 208, 320, 384, 448, 512, 528, 560};
        chk_ppm(590);
        chk_tail(577, -1, 590);
        chk_quiet(2, 590);

        // second byte withheld: underrun then end marker
        qb[0] = 8'h1B; ql[0] = 1'b0;
        frame(0, 1, 331, -1);
        ivs = '{1, 81, 161, 241, 257, 289};
        ive = '{16, 96, 176, 256, 272, 304};
        chk_ppm(330);
        chk_tail(321, 257, 330);
        chk("ready_reopens", rd[acc0 + 1], 1);
        chk_quiet(257, 330);

        // reset in the middle of symbol 2, during its low slot
        qb[0] = 8'h1B; ql[0] = 1'b1;
        frame(0, 1, 166, -1);
        chk("pre_reset_ppm", ppm, 0);
        chk("pre_reset_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_ppm", ppm, 1);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_ready", rdy, 0);
        chk("async_rst_done", done, 0);
        step(); step();
        rst_n = 1'b1;
        step();
        qb[0] = 8'hE4; ql[0] = 1'b1;
        frame(0, 1, 331, -1);
        ivs = '{49, 97, 145, 193, 257, 289};
        ive = '{64, 112, 160, 208, 272, 304};
        chk_ppm(330);
        chk_tail(321, -1, 330);

        // SLOT_CYC=2 instance
        sel = 1'b1;
        rst_n = 1'b0;
        step(); step();
        rst_n = 1'b1;
        step();
        frame(0, 1, 46, -1);
        ivs = '{7, 13, 19, 25, 33, 37};
        ive = '{8, 14, 20, 26, 34, 38};
        chk_ppm(45);
        chk_tail(41, -1, 45);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
